// File: rtl/btb_sa.sv
// btb_sa: set-associative branch target buffer; lookup result is registered one cycle after pc.
// Optional build macro BTB_PLRU_EN selects per-set tree pseudo-LRU, otherwise a global round-robin victim.
// Tag/target arrays are unreset flops; only valid bits, replacement state and outputs are reset.
module btb_sa #(
  parameter int ADDR_LEN = 32,
  parameter int IDX_SEL  = 4,
  parameter int WAYS     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_LEN-1:0] pc,
  input  logic                invalid2,
  output logic                hit,
  output logic                hit_slot,
  output logic [ADDR_LEN-1:0] jmpaddr,
  input  logic                we,
  input  logic [ADDR_LEN-1:0] jmpsrc,
  input  logic [ADDR_LEN-1:0] jmpdst,
  input  logic                inv,
  input  logic                flush
);
  localparam int SETS = 1 << IDX_SEL;
  localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]     valid [SETS];
  logic [ADDR_LEN-1:0] tag_q [SETS][WAYS];
  logic [ADDR_LEN-1:0] tgt_q [SETS][WAYS];

  logic [ADDR_LEN-1:0] pc4;
  logic [IDX_SEL-1:0]  s0, s1, ws, l_set;
  logic [WAYS-1:0]     m0, m1, wmatch;
  logic                l_hit, l_slot, we_eff;
  logic [WB-1:0]       l_way, w_way, victim;
  logic [ADDR_LEN-1:0] l_tgt;

  assign pc4    = pc + ADDR_LEN'(4);
  assign s0     = pc[3 +: IDX_SEL];
  // slot1 is looked up in the set its own address lives in; identical to s0 for 8-byte aligned bundles
  assign s1     = pc4[3 +: IDX_SEL];
  assign ws     = jmpsrc[3 +: IDX_SEL];
  assign we_eff = we & ~inv & ~flush;

  // Lookup: slot0 beats slot1, lowest matching way wins within a slot
  always_comb begin
    m0    = '0;
    m1    = '0;
    l_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      m0[w] = valid[s0][w] && (tag_q[s0][w] == pc);
      m1[w] = valid[s1][w] && (tag_q[s1][w] == pc4) && !invalid2;
    end
    for (int w = WAYS - 1; w >= 0; w--) if (m1[w]) l_way = WB'(w);
    for (int w = WAYS - 1; w >= 0; w--) if (m0[w]) l_way = WB'(w);
    l_hit  = (|m0) | (|m1);
    l_slot = ~(|m0) & (|m1);
    l_set  = l_slot ? s1 : s0;
    l_tgt  = l_hit ? tgt_q[l_set][l_way] : '0;
  end

  // Write/inv way: existing tag match, else lowest invalid way, else replacement victim
  always_comb begin
    wmatch = '0;
    w_way  = victim;
    for (int w = 0; w < WAYS; w++)
      wmatch[w] = valid[ws][w] && (tag_q[ws][w] == jmpsrc);
    for (int w = WAYS - 1; w >= 0; w--) if (!valid[ws][w]) w_way = WB'(w);
    for (int w = WAYS - 1; w >= 0; w--) if (wmatch[w]) w_way = WB'(w);
  end

`ifdef BTB_PLRU_EN
  localparam int PB = (WAYS > 1) ? WAYS - 1 : 1;
  logic [PB-1:0] plru [SETS];
  logic [PB-1:0] plru_wbase;

  // Point tree bits away from the used way (root bit 0, children 1 = lower half, 2 = upper half)
  function automatic logic [PB-1:0] plru_touch(input logic [PB-1:0] b, input logic [WB-1:0] w);
    logic [2:0] bb;
    logic [1:0] ww;
    bb = 3'(b);
    ww = 2'(w);
    if (WAYS == 2) begin
      bb[0] = ~ww[0];
    end else if (WAYS == 4) begin
      bb[0] = ~ww[1];
      if (ww[1]) bb[2] = ~ww[0];
      else       bb[1] = ~ww[0];
    end
    return PB'(bb);
  endfunction

  // Follow the tree bits; a 0 bit selects the lower half
  function automatic logic [WB-1:0] plru_victim(input logic [PB-1:0] b);
    logic [2:0] bb;
    logic [1:0] v;
    bb = 3'(b);
    v  = 2'b00;
    if (WAYS == 2)      v = {1'b0, bb[0]};
    else if (WAYS == 4) v = bb[0] ? {1'b1, bb[2]} : {1'b0, bb[1]};
    return WB'(v);
  endfunction

  assign victim     = plru_victim(plru[ws]);
  // A same-cycle lookup use in the written set is folded in before the write use
  assign plru_wbase = (l_hit && (l_set == ws)) ? plru_touch(plru[ws], l_way) : plru[ws];

  // Pseudo-LRU state: lookup hits and writes count as uses
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int s = 0; s < SETS; s++) plru[s] <= '0;
    end else begin
      if (l_hit)  plru[l_set] <= plru_touch(plru[l_set], l_way);
      if (we_eff) plru[ws]    <= plru_touch(plru_wbase, w_way);
    end
  end
`else
  logic [WB-1:0] rr;

  assign victim = rr;

  // Global round-robin pointer advances only when a full set is overwritten on a tag miss
  always_ff @(posedge clk) begin
    if (reset || flush)
      rr <= '0;
    else if (we_eff && !(|wmatch) && (&valid[ws]) && (WAYS > 1))
      rr <= rr + WB'(1);
  end
`endif

  // Valid bits and registered lookup outputs; reset > flush > inv > we
  always_ff @(posedge clk) begin
    if (reset) begin
      hit      <= 1'b0;
      hit_slot <= 1'b0;
      jmpaddr  <= '0;
      for (int s = 0; s < SETS; s++) valid[s] <= '0;
    end else begin
      hit      <= l_hit;
      hit_slot <= l_slot;
      jmpaddr  <= l_tgt;
      if (flush) begin
        for (int s = 0; s < SETS; s++) valid[s] <= '0;
      end else if (inv) begin
        if (|wmatch) valid[ws][w_way] <= 1'b0;
      end else if (we) begin
        valid[ws][w_way] <= 1'b1;
      end
    end
  end

  // Tag/target arrays, no reset; an in-place update rewrites the same tag
  always_ff @(posedge clk) begin
    if (!reset && we_eff) begin
      tag_q[ws][w_way] <= jmpsrc;
      tgt_q[ws][w_way] <= jmpdst;
    end
  end

endmodule

// File: tb/tb_btb_sa.sv
// tb_btb_sa: directed vector table plus randomized traffic against an associative reference model.
// Default geometry: 32-bit addresses, 16 sets, 2 ways.
module tb_btb_sa;
  localparam int AL   = 32;
  localparam int SETS = 16;
  localparam int WAYS = 2;

  logic          clk;
  logic          reset, invalid2, we, inv, flush;
  logic [AL-1:0] pc, jmpsrc, jmpdst;
  logic          hit, hit_slot;
  logic [AL-1:0] jmpaddr;

  int nvec = 0;
  int nerr = 0;

  btb_sa #(.ADDR_LEN(AL), .IDX_SEL(4), .WAYS(WAYS)) dut (
    .clk(clk), .reset(reset), .pc(pc), .invalid2(invalid2),
    .hit(hit), .hit_slot(hit_slot), .jmpaddr(jmpaddr),
    .we(we), .jmpsrc(jmpsrc), .jmpdst(jmpdst), .inv(inv), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            rst;
    logic [AL-1:0] pc;
    bit            inv2;
    bit            we;
    logic [AL-1:0] src;
    logic [AL-1:0] dst;
    bit            inv;
    bit            fl;
    bit            eh;
    bit            es;
    logic [AL-1:0] ea;
  } vec_t;

  vec_t tab[$];

  // ---------------- reference model: a table of (valid, source, target) entries per set
  bit            mv   [SETS][WAYS];
  logic [AL-1:0] mtag [SETS][WAYS];
  logic [AL-1:0] mtgt [SETS][WAYS];
`ifdef BTB_PLRU_EN
  int mru [SETS];
`else
  int rr;
`endif

  function automatic int idx(input logic [AL-1:0] a);
    return int'(a[6:3]);
  endfunction

  function automatic int find(input logic [AL-1:0] a);
    int s;
    s = idx(a);
    for (int w = 0; w < WAYS; w++)
      if (mv[s][w] && mtag[s][w] == a) return w;
    return -1;
  endfunction

  function automatic int victim_of(input int s);
`ifdef BTB_PLRU_EN
    return 1 - mru[s];
`else
    if (s < 0) return 0;
    return rr;
`endif
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
`ifdef BTB_PLRU_EN
      mru[s] = 1;
`endif
    end
`ifndef BTB_PLRU_EN
    rr = 0;
`endif
  endtask

  task automatic model_step(input vec_t v, output bit eh, output bit es, output logic [AL-1:0] ea);
    int w0, w1, ls, lw, ss, wf, ww;
    bit repl;
    eh = 0; es = 0; ea = '0;
    if (v.rst) begin model_clear(); return; end
    w0 = find(v.pc);
    w1 = v.inv2 ? -1 : find(v.pc + 32'd4);
    ls = -1; lw = 0;
    if (w0 >= 0) begin
      eh = 1; ls = idx(v.pc); lw = w0; ea = mtgt[ls][lw];
    end else if (w1 >= 0) begin
      eh = 1; es = 1; ls = idx(v.pc + 32'd4); lw = w1; ea = mtgt[ls][lw];
    end
    if (v.fl) begin model_clear(); return; end
    ss = idx(v.src);
    wf = find(v.src);
    ww = wf; repl = 0;
    for (int w = 0; w < WAYS; w++) if (ww < 0 && !mv[ss][w]) ww = w;
    if (ww < 0) begin ww = victim_of(ss); repl = 1; end
`ifdef BTB_PLRU_EN
    if (ls >= 0) mru[ls] = lw;
`endif
    if (v.inv) begin
      if (wf >= 0) mv[ss][wf] = 1'b0;
    end else if (v.we) begin
      mv[ss][ww] = 1'b1; mtag[ss][ww] = v.src; mtgt[ss][ww] = v.dst;
`ifdef BTB_PLRU_EN
      mru[ss] = ww;
`else
      if (repl) rr = (rr + 1) % WAYS;
`endif
    end
  endtask

  // ---------------- stimulus helpers
  function automatic vec_t mk(bit r, logic [AL-1:0] p, bit i2, bit w_e, logic [AL-1:0] s,
                              logic [AL-1:0] d, bit iv, bit fl, bit eh, bit es, logic [AL-1:0] ea);
    vec_t v;
    v.rst = r; v.pc = p; v.inv2 = i2; v.we = w_e; v.src = s; v.dst = d;
    v.inv = iv; v.fl = fl; v.eh = eh; v.es = es; v.ea = ea;
    return v;
  endfunction

  // Drive one cycle, advance past the edge, compare against the table or the model
  task automatic apply(input vec_t v, input bit use_tab, input string name, input int n);
    bit meh, mes;
    logic [AL-1:0] mea;
    reset = v.rst; pc = v.pc; invalid2 = v.inv2; we = v.we;
    jmpsrc = v.src; jmpdst = v.dst; inv = v.inv; flush = v.fl;
    model_step(v, meh, mes, mea);
    if (use_tab) begin meh = v.eh; mes = v.es; mea = v.ea; end
    @(posedge clk); #1;
    nvec++;
    if (hit !== meh || hit_slot !== mes || jmpaddr !== mea) begin
      nerr++;
      $display("FAIL %s #%0d pc=%h: got hit=%0b slot=%0b addr=%h, want hit=%0b slot=%0b addr=%h",
               name, n, v.pc, hit, hit_slot, jmpaddr, meh, mes, mea);
    end
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; pc = '0; invalid2 = 1'b0; we = 1'b0; jmpsrc = '0; jmpdst = '0;
    inv = 1'b0; flush = 1'b0;
    model_clear();

    //         rst pc      i2 we src     dst     inv fl  hit sl addr
    tab.push_back(mk(1, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 32'h100, 0, 1, 32'h108, 32'h400, 0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 32'h104, 0, 0, 32'h0,   32'h0,   0, 0, 1, 1, 32'h400));
    tab.push_back(mk(0, 32'h104, 1, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 32'h200, 0, 1, 32'h200, 32'h300, 0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 32'h200, 0, 0, 32'h0,   32'h0,   0, 0, 1, 0, 32'h300));
    tab.push_back(mk(0, 32'h100, 0, 1, 32'h200, 32'h500, 0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 32'h200, 0, 0, 32'h0,   32'h0,   0, 0, 1, 0, 32'h500));
    tab.push_back(mk(0, 32'h104, 0, 0, 32'h0,   32'h0,   0, 0, 1, 1, 32'h400));
    tab.push_back(mk(0, 32'h300, 0, 1, 32'h204, 32'h600, 0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 32'h200, 0, 0, 32'h0,   32'h0,   0, 0, 1, 0, 32'h500));
    tab.push_back(mk(0, 32'h200, 1, 0, 32'h0,   32'h0,   0, 0, 1, 0, 32'h500));
    // replacement in a full set 0
    tab.push_back(mk(1, 32'h300, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 32'h300, 0, 1, 32'h000, 32'hA00, 0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 32'h300, 0, 1, 32'h080, 32'hA80, 0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 32'h000, 0, 0, 32'h0,   32'h0,   0, 0, 1, 0, 32'hA00));
    tab.push_back(mk(0, 32'h300, 0, 1, 32'h100, 32'hB00, 0, 0, 0, 0, 32'h0));
`ifdef BTB_PLRU_EN
    tab.push_back(mk(0, 32'h000, 0, 0, 32'h0,   32'h0,   0, 0, 1, 0, 32'hA00));
    tab.push_back(mk(0, 32'h080, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0));
`else
    tab.push_back(mk(0, 32'h000, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 32'h080, 0, 0, 32'h0,   32'h0,   0, 0, 1, 0, 32'hA80));
`endif
    tab.push_back(mk(0, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 1, 0, 32'hB00));
    // inv beats we, flush sees pre-flush contents, reset drops a write
    tab.push_back(mk(0, 32'h300, 0, 1, 32'h080, 32'hC00, 1, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 32'h080, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 32'h100, 0, 0, 32'h0,   32'h0,   0, 1, 1, 0, 32'hB00));
    tab.push_back(mk(0, 32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0));
    tab.push_back(mk(1, 32'h100, 0, 1, 32'h180, 32'hD00, 0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 32'h180, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 32'h300, 0, 1, 32'h180, 32'hD00, 0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 32'h180, 0, 0, 32'h0,   32'h0,   0, 0, 1, 0, 32'hD00));
    tab.push_back(mk(0, 32'h180, 0, 1, 32'h180, 32'hE00, 0, 1, 1, 0, 32'hD00));
    tab.push_back(mk(0, 32'h180, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0));

    for (int i = 0; i < tab.size(); i++) apply(tab[i], 1'b1, "table", i);

    // same-set conflicts galore: 256 possible sources over 16 sets x 2 ways
    for (int i = 0; i < 3000; i++) begin
      v.rst  = ($urandom_range(0, 199) == 0);
      v.pc   = 32'($urandom_range(0, 127)) << 3;
      v.inv2 = ($urandom_range(0, 9) < 3);
      v.we   = ($urandom_range(0, 9) < 4);
      v.src  = ($urandom_range(0, 1) == 0) ? (v.pc + 32'(4 * $urandom_range(0, 1)))
                                           : (32'($urandom_range(0, 255)) << 2);
      v.dst  = $urandom;
      v.inv  = ($urandom_range(0, 9) == 0);
      v.fl   = ($urandom_range(0, 99) == 0);
      v.eh = 0; v.es = 0; v.ea = '0;
      apply(v, 1'b0, "random", i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/btb_sa.md
# btb_sa

Set-associative branch target buffer for the fetch stage. It is the parametrised successor of the direct-mapped BTB, with configurable index width, associativity and address width, a registered lookup, per-entry invalidate and whole-table flush. Fetch presents the bundle PC each cycle and receives a hit indication and predicted target one cycle later. The branch unit writes resolved taken jumps and invalidates mispredicted entries.

## Interface
- ADDR_LEN, 32: address and target width.
- IDX_SEL, 4: set index bits; sets = 2**IDX_SEL; index = addr[3 +: IDX_SEL].
- WAYS, 2: associativity; legal values 1, 2, 4.

- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- pc  in  ADDR_LEN  fetch bundle address (slot0 = pc, slot1 = pc+4).
- invalid2  in  1  slot1 not valid in this bundle; suppresses slot1 match.
- hit  out  1  registered; a valid entry matched pc or pc+4.
- hit_slot  out  1  registered; 0 = matched pc, 1 = matched pc+4.
- jmpaddr  out  ADDR_LEN  registered predicted target; 0 when hit=0.
- we  in  1  write/update entry.
- jmpsrc  in  ADDR_LEN  branch source address for we/inv.
- jmpdst  in  ADDR_LEN  branch target for we.
- inv  in  1  invalidate the entry whose tag equals jmpsrc.
- flush  in  1  clear all valid bits.

## Operation
- Storage: per set and way, a valid bit, a full ADDR_LEN tag (source address) and an ADDR_LEN target. Arrays are flops and are not reset; only valid bits and replacement state are reset.
- Lookup:
  - Set s = pc[3 +: IDX_SEL].
  - m0[w] = valid & tag==pc.
  - m1[w] = valid & tag==pc+4 & ~invalid2 (pc+4 is computed modulo 2**ADDR_LEN).
  - hit = |m0 | |m1.
  - Slot0 has priority over slot1. Within a slot, the lowest-numbered matching way wins.
  - jmpaddr takes that way's target; hit_slot = ~|m0 & |m1.
- Write (we=1), set ws = jmpsrc[3 +: IDX_SEL]:
  - If a valid way in ws has tag==jmpsrc, update its target in place; no allocation. Duplicate tags within a set can therefore never be created.
  - Else, if an invalid way exists, fill the lowest-numbered one.
  - Else, replace the victim chosen by the replacement policy (see Configuration).
  - The written way sets valid=1.
- inv=1: clear valid on the way in set jmpsrc[3 +: IDX_SEL] whose tag==jmpsrc. No match means no effect.
- Priority, highest first: reset > flush > inv > we.
  - we and inv in the same cycle: inv wins and the write is dropped.
  - flush drops we and inv in the same cycle.
- A lookup hit on slot0 or slot1 counts as a use for replacement state. A write, fill or update also counts as a use of the written way.

## Timing
- Lookup latency 1: pc sampled at edge N; hit, hit_slot and jmpaddr are valid after edge N until edge N+1.
- Write, inv and flush commit at edge N. A lookup sampled at edge N sees the pre-update contents; a lookup sampled at edge N+1 sees the new contents. There is no write-to-read bypass.
- Reset at edge N:
  - All valid bits = 0 and replacement state = 0.
  - hit=0, hit_slot=0, jmpaddr=0 after edge N.
  - Any we/inv/lookup in that cycle is discarded.
- Reset asserted mid-stream: the next lookup result after reset deasserts reflects an empty table (hit=0).
- Flush: same as reset for valid bits and replacement state. The registered outputs still reflect the lookup of the flush cycle, evaluated against pre-flush contents.
- Full set, write miss: exactly one way is replaced; the other ways are untouched.
- WAYS=1: the victim is always way 0 and replacement state is absent.

## Configuration
- BTB_PLRU_EN defined: per-set tree pseudo-LRU (WAYS-1 bits per set).
  - On each use, bits are pointed away from the used way.
  - The victim follows the bits (bit=0 selects the lower half).
- BTB_PLRU_EN undefined: one global round-robin counter of log2(WAYS) bits.
  - The victim is the counter value.
  - The counter increments, wrapping, only on a replacing write.
  - Lookups do not affect it.

## Test plan
- Reset, then pc=0x100 -> next cycle hit=0, jmpaddr=0.
- we jmpsrc=0x108 jmpdst=0x400; then pc=0x104, invalid2=0 -> hit=1, hit_slot=1, jmpaddr=0x400. Repeat with invalid2=1 -> hit=0.
- Same-cycle write and lookup: we jmpsrc=0x200 jmpdst=0x300 with pc=0x200 -> hit=0 in the following cycle; the repeated lookup one cycle later gives hit=1, jmpaddr=0x300.
- Rewrite jmpsrc=0x200 jmpdst=0x500 -> in-place update, the other way is untouched. Lookup 0x200 -> jmpaddr=0x500.
- WAYS=2, IDX_SEL=4, set 0: write 0x000, then 0x080, lookup 0x000, then write 0x100.
  - With BTB_PLRU_EN: 0x080 is evicted; 0x000 still hits.
  - Without: the victim is way 0, so 0x000 is evicted and 0x080 still hits.
- inv jmpsrc=0x080 together with we jmpsrc=0x080 -> entry invalid, lookup misses. Then flush -> all lookups miss. Then reset mid-write -> the write is discarded.
